wb_ahb_bridge: RTL
==================

Name: wb_ahb_bridge

Overview:
- Wishbone-classic slave to AHB-Lite (HASTI) single-master bridge. Gives the management SoC load/store access to the AIRISC imem/dmem address space.
- Sits between the user-area Wishbone port and an AHB-Lite memory/peripheral port inside the user project wrapper.
- Replaces the ad-hoc valid/wstrb glue with a parametrised, wait-state-aware, address-windowed transfer engine.

Parameters:
- BASE_ADDR, 32'h3000_0000: Wishbone window base; compare uses bits [31:WINDOW_BITS] only.
- WINDOW_BITS, 16: window size is 2^WINDOW_BITS bytes; the offset becomes the AHB address.
- HADDR_W, 32: AHB address width; offset is zero-extended into it.
- TIMEOUT, 255: hready-low cycle limit. Used only with the optional feature; 1..65535.

Ports:
- clk  in  1  single clock for both sides
- nreset  in  1  asynchronous, active-low reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  one-cycle acknowledge
- wbs_dat_o  out  32  registered read data
- haddr  out  HADDR_W  AHB address
- hwrite  out  1  AHB write
- hsize  out  3  AHB transfer size
- hburst  out  3  AHB burst type
- hmastlock  out  1  AHB lock
- hprot  out  4  AHB protection
- htrans  out  2  AHB transfer type
- hwdata  out  32  AHB write data
- hrdata  in  32  AHB read data
- hready  in  1  AHB ready
- hresp  in  1  AHB response (1 = ERROR)
- bus_err_o  out  1  one-cycle pulse on an error or rejected transfer

Behaviour:
- Reset (async, nreset=0): state IDLE, htrans=IDLE(2'b00), wbs_ack_o=0, wbs_dat_o=0, bus_err_o=0, haddr=0, hwdata=0, hwrite=0, hsize=0.
- A reset mid-transfer aborts at once; no ack is issued for that transfer.
- Constant outputs: hburst=SINGLE(3'b000), hmastlock=0, hprot=4'b0011.
- valid = wbs_cyc_i & wbs_stb_i, sampled only in IDLE.
- FSM states: IDLE, ADDR, DATA, ACK.
- IDLE: on valid, register address offset, we, sel and dat_i, then decode:
  - Out of window (adr[31:WINDOW_BITS] != BASE_ADDR[31:WINDOW_BITS]) -> ACK with dat=0 and a bus_err_o pulse; no AHB activity.
  - sel 4'b1111 -> hsize=2.
  - sel 4'b0011 or 4'b1100 -> hsize=1.
  - sel with exactly one bit set -> hsize=0.
  - Any other sel (including 0) -> treated as out of window.
  - Legal transfer -> ADDR.
- ADDR: htrans=NONSEQ(2'b10), haddr = zero-extended offset with low bits aligned to hsize, hwrite=we. On hready=1 -> DATA; otherwise stay.
- DATA: htrans=IDLE and hwdata=registered wbs_dat_i. On hready=1:
  - Read: capture hrdata into wbs_dat_o.
  - hresp=1: wbs_dat_o=32'hFFFF_FFFF and a bus_err_o pulse.
  - Then -> ACK.
- ACK: wbs_ack_o=1 for exactly one cycle, then -> IDLE.
  - After ack, valid is re-sampled in IDLE on the following cycle, so back-to-back transfers each take a fresh pass.
- Latency with zero wait states: valid sampled at edge k -> ack high in the cycle after edge k+3. Each hready-low cycle in ADDR or DATA adds one cycle.
- wbs_dat_o holds its value between transfers. Writes leave wbs_dat_o unchanged.
- Wishbone inputs are ignored outside IDLE. A master dropping stb mid-transfer does not abort; the ack is still issued.

Optional Feature:
- Macro: WB_AHB_TIMEOUT_EN.
- Defined: a counter clears on entering ADDR and increments each cycle hready=0 in ADDR or DATA. When it reaches TIMEOUT:
  - force htrans=IDLE;
  - wbs_dat_o=32'hDEAD_BEEF;
  - pulse bus_err_o;
  - go to ACK.
- Not defined: no counter is synthesised, and the bridge waits indefinitely for hready.

Test Plan:
- Word write 0x3000_0010 dat 0x1234_5678 sel 1111, hready=1 -> haddr=0x10, hsize=2, htrans NONSEQ for one cycle, hwdata=0x1234_5678 in the next cycle, ack 4 cycles after stb.
- Byte read 0x3000_0003 sel 1000, hrdata=0xAB00_0000 with 2 wait states in DATA -> hsize=0, wbs_dat_o=0xAB00_0000, ack delayed by 2 cycles.
- Access to 0x3001_0000 (out of window) or sel 0101 -> no NONSEQ, ack next-but-one cycle, dat=0, bus_err_o pulse.
- Read with hresp=1 -> wbs_dat_o=0xFFFF_FFFF, bus_err_o pulse coincident with entering ACK, ack single cycle.
- nreset low during DATA -> htrans=IDLE and ack=0 immediately; after release, the next read completes normally.
- WB_AHB_TIMEOUT_EN, TIMEOUT=8, hready held low -> ack after 8 stall cycles, dat 0xDEAD_BEEF, bus_err_o pulse. With the macro undefined, no ack is issued within 1000 cycles.

Source files
------------

// File: rtl/wb_ahb_bridge.sv
// Wishbone-classic slave to AHB-Lite single-master bridge with an address window.
// Optional hready-low timeout is enabled by defining WB_AHB_TIMEOUT_EN.
module wb_ahb_bridge #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned WINDOW_BITS = 16,
    parameter int unsigned HADDR_W     = 32,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic [HADDR_W-1:0] haddr,
    output logic               hwrite,
    output logic [2:0]         hsize,
    output logic [2:0]         hburst,
    output logic               hmastlock,
    output logic [3:0]         hprot,
    output logic [1:0]         htrans,
    output logic [31:0]        hwdata,
    input  logic [31:0]        hrdata,
    input  logic               hready,
    input  logic               hresp,
    output logic               bus_err_o
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ACK} state_t;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_ahb_bridge: TIMEOUT must be within 1..65535");
    end

    state_t                 state, state_d;
    logic                   pend, pend_d;
    logic                   capture;
    logic [WINDOW_BITS-1:0] req_off;
    logic                   req_we;
    logic                   req_hit;
    logic [3:0]             req_sel;
    logic [31:0]            req_dat;

    logic [2:0]             req_size;
    logic                   sel_ok;
    logic                   req_legal;
    logic [WINDOW_BITS-1:0] req_aligned;
    logic                   timeout_c;

    logic [1:0]             htrans_d;
    logic                   ack_d;
    logic                   err_d;
    logic [31:0]            dat_d;
    logic [HADDR_W-1:0]     haddr_d;
    logic                   hwrite_d;
    logic [2:0]             hsize_d;
    logic [31:0]            hwdata_d;

    assign hburst    = 3'b000;
    assign hmastlock = 1'b0;
    assign hprot     = 4'b0011;

    // Byte-select decode to transfer size; unsupported patterns are rejected like a window miss.
    always_comb begin
        req_size = 3'd0;
        sel_ok   = 1'b1;
        case (req_sel)
            4'b1111:                            req_size = 3'd2;
            4'b0011, 4'b1100:                   req_size = 3'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: req_size = 3'd0;
            default:                            sel_ok   = 1'b0;
        endcase
        req_aligned = req_off;
        if (req_size == 3'd2) begin
            req_aligned[1:0] = 2'b00;
        end else if (req_size == 3'd1) begin
            req_aligned[0] = 1'b0;
        end
    end

    assign req_legal = req_hit & sel_ok;

`ifdef WB_AHB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] to_cnt;

    // Counts stalled cycles of the current transfer; idle clears it before every ADDR entry.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            to_cnt <= '0;
        end else if (state == S_IDLE) begin
            to_cnt <= '0;
        end else if ((state == S_ADDR || state == S_DATA) && !hready) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    assign timeout_c = (state == S_ADDR || state == S_DATA) && !hready && (to_cnt == TO_LAST);
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= S_IDLE;
            pend  <= 1'b0;
        end else begin
            state <= state_d;
            pend  <= pend_d;
        end
    end

    // Next state and next values of all registered bus outputs.
    always_comb begin
        state_d  = state;
        pend_d   = pend;
        capture  = 1'b0;
        htrans_d = HTRANS_IDLE;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = wbs_dat_o;
        haddr_d  = haddr;
        hwrite_d = hwrite;
        hsize_d  = hsize;
        hwdata_d = hwdata;
        case (state)
            S_IDLE: begin
                if (pend) begin
                    pend_d = 1'b0;
                    if (req_legal) begin
                        state_d  = S_ADDR;
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = HADDR_W'(req_aligned);
                        hwrite_d = req_we;
                        hsize_d  = req_size;
                    end else begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        dat_d   = 32'h0;
                    end
                end else if (wbs_cyc_i && wbs_stb_i) begin
                    capture = 1'b1;
                    pend_d  = 1'b1;
                end
            end
            S_ADDR: begin
                if (hready) begin
                    state_d  = S_DATA;
                    hwdata_d = req_dat;
                end else begin
                    htrans_d = HTRANS_NONSEQ;
                end
            end
            S_DATA: begin
                if (hready) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    if (hresp) begin
                        dat_d = 32'hFFFF_FFFF;
                        err_d = 1'b1;
                    end else if (!req_we) begin
                        dat_d = hrdata;
                    end
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (timeout_c) begin
            state_d  = S_ACK;
            htrans_d = HTRANS_IDLE;
            ack_d    = 1'b1;
            err_d    = 1'b1;
            dat_d    = 32'hDEAD_BEEF;
        end
    end

    // Request capture: Wishbone inputs are only looked at while idle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            req_off <= '0;
            req_we  <= 1'b0;
            req_hit <= 1'b0;
            req_sel <= 4'h0;
            req_dat <= 32'h0;
        end else if (capture) begin
            req_off <= wbs_adr_i[WINDOW_BITS-1:0];
            req_we  <= wbs_we_i;
            req_hit <= (wbs_adr_i[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS]);
            req_sel <= wbs_sel_i;
            req_dat <= wbs_dat_i;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            htrans    <= HTRANS_IDLE;
            wbs_ack_o <= 1'b0;
            bus_err_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            haddr     <= '0;
            hwrite    <= 1'b0;
            hsize     <= 3'd0;
            hwdata    <= 32'h0;
        end else begin
            htrans    <= htrans_d;
            wbs_ack_o <= ack_d;
            bus_err_o <= err_d;
            wbs_dat_o <= dat_d;
            haddr     <= haddr_d;
            hwrite    <= hwrite_d;
            hsize     <= hsize_d;
            hwdata    <= hwdata_d;
        end
    end

endmodule
